// File: rtl/multicycle_control_if.sv
// Control-side bundle of the multi-cycle RV32I core: opcode and memory handshake in,
// datapath strobes out. master = control FSM, slave = datapath / memory side.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       branch;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       instr_done;
  logic       trap;
  logic [3:0] state;

  modport master (
    input  opcode,
    input  mem_ready,
    output mem_req,
    output mem_write,
    output adr_src,
    output ir_write,
    output pc_write,
    output branch,
    output reg_write,
    output alu_src_a,
    output alu_src_b,
    output alu_op,
    output result_src,
    output instr_done,
    output trap,
    output state
  );

  modport slave (
    output opcode,
    output mem_ready,
    input  mem_req,
    input  mem_write,
    input  adr_src,
    input  ir_write,
    input  pc_write,
    input  branch,
    input  reg_write,
    input  alu_src_a,
    input  alu_src_b,
    input  alu_op,
    input  result_src,
    input  instr_done,
    input  trap,
    input  state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/memory/
// writeback, drives datapath strobes and arbitrates the unified memory port with a watchdog.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TW          = 5
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StJalrLink = 4'd12,
    StExecU    = 4'd13,
    StTrap     = 4'd14,
    StUnused   = 4'd15
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam bit            WatchdogEn  = (MEM_TIMEOUT != 0);
  localparam logic [TW-1:0] TimeoutLast = TW'(MEM_TIMEOUT - 1);

  state_e        r_state;
  state_e        w_state_d;
  logic [TW-1:0] r_cnt;
  logic          w_waiting;
  logic          w_timeout;

  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_reg_write;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_result_src;
  logic       w_trap;
  logic       w_instr_done;

  function automatic state_e decode_op(input logic [6:0] op);
    state_e s;
    case (op)
      OpLoad, OpStore: s = StMemAdr;
      OpReg:           s = StExecR;
      OpImm:           s = StExecI;
      OpBranch:        s = StBranch;
      OpJal:           s = StJal;
      OpJalr:          s = StJalr;
      OpLui, OpAuipc:  s = StExecU;
      default:         s = StTrap;
    endcase
    return s;
  endfunction

  // Watchdog only ever runs while a memory access is outstanding and unanswered.
  assign w_waiting = w_mem_req & ~bus.mem_ready;
  assign w_timeout = WatchdogEn && w_waiting && (r_cnt == TimeoutLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StFetch;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_waiting ? r_cnt + TW'(1) : '0;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StFetch:    if (bus.mem_ready) w_state_d = StDecode;
      StDecode:   w_state_d = decode_op(bus.opcode);
      StMemAdr:   w_state_d = (bus.opcode == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (bus.mem_ready) w_state_d = StMemWb;
      StMemWb:    w_state_d = StFetch;
      StMemWrite: if (bus.mem_ready) w_state_d = StFetch;
      StExecR:    w_state_d = StAluWb;
      StExecI:    w_state_d = StAluWb;
      StExecU:    w_state_d = StAluWb;
      StJal:      w_state_d = StAluWb;
      StJalrLink: w_state_d = StAluWb;
      StAluWb:    w_state_d = StFetch;
      StBranch:   w_state_d = StFetch;
      StJalr:     w_state_d = StJalrLink;
      StTrap:     w_state_d = StTrap;
      default:    w_state_d = StTrap;
    endcase
    if (w_timeout) w_state_d = StTrap;
  end

  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_result_src = 2'b00;
    w_trap       = 1'b0;
    case (r_state)
      StFetch: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        // IR/PC capture only on the cycle memory answers, never while reset is asserted.
        w_ir_write   = bus.mem_ready & ~reset;
        w_pc_write   = bus.mem_ready & ~reset;
      end
      StDecode: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
      end
      StMemAdr: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      StMemRead: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      StMemWb: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      StMemWrite: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
      end
      StExecR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
      end
      StExecI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      StAluWb: w_reg_write = 1'b1;
      StBranch: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
      end
      StJal: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = ~reset;
      end
      StJalr: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      StJalrLink: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = ~reset;
      end
      StExecU: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      StTrap:  w_trap = 1'b1;
      default: w_trap = 1'b0;
    endcase
  end

  // Retirement: leaving a non-fetch state back to FETCH; TRAP never reaches FETCH on its own.
  assign w_instr_done = ~reset && (r_state != StFetch) && (w_state_d == StFetch);

  assign bus.mem_req    = w_mem_req;
  assign bus.mem_write  = w_mem_write;
  assign bus.adr_src    = w_adr_src;
  assign bus.ir_write   = w_ir_write;
  assign bus.pc_write   = w_pc_write;
  assign bus.branch     = w_branch;
  assign bus.reg_write  = w_reg_write;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.result_src = w_result_src;
  assign bus.instr_done = w_instr_done;
  assign bus.trap       = w_trap;
  assign bus.state      = r_state;

endmodule
